// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake, CMP->Jcc flag
// interlock, illegal-opcode detection and synchronous flush.
module decode_stage #(
  parameter int DATA_W     = 32,
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 16,
  parameter int FLAG_W     = 8,
  parameter int PC_W       = DATA_W - OPCODE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [DATA_W-1:0]     instruction,
  input  logic [FLAG_W-1:0]     status_reg,
  input  logic                  flags_update,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [3:0]            alu_op,
  output logic [REG_ADDR_W-1:0] alu_src1,
  output logic [REG_ADDR_W-1:0] alu_src2,
  output logic [REG_ADDR_W-1:0] alu_dest,
  output logic                  reg_write_enable,
  output logic                  imm,
  output logic                  load_pc,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_data_in,
  output logic [DATA_W-1:0]     imm_val,
  output logic [PC_W-1:0]       load_pc_val,
  output logic                  illegal
);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'('h00);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'('h01);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'('h02);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'('h03);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'('h04);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'('h05);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'('h06);
  localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'('h07);
  localparam logic [OPCODE_W-1:0] OP_LLI  = OPCODE_W'('h08);
  localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'('h0A);
  localparam logic [OPCODE_W-1:0] OP_JEQ  = OPCODE_W'('h0B);
  localparam logic [OPCODE_W-1:0] OP_LOD  = OPCODE_W'('h0C);
  localparam logic [OPCODE_W-1:0] OP_STR  = OPCODE_W'('h0D);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'('h0E);
  localparam logic [OPCODE_W-1:0] OP_XNOR = OPCODE_W'('h0F);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'('h10);
  localparam logic [OPCODE_W-1:0] OP_SHR  = OPCODE_W'('h11);
  localparam logic [OPCODE_W-1:0] OP_JNE  = OPCODE_W'('h12);
  localparam logic [OPCODE_W-1:0] OP_JB   = OPCODE_W'('h13);
  localparam logic [OPCODE_W-1:0] OP_JBE  = OPCODE_W'('h14);
  localparam logic [OPCODE_W-1:0] OP_JL   = OPCODE_W'('h15);
  localparam logic [OPCODE_W-1:0] OP_JLE  = OPCODE_W'('h16);

  // Conditional jumps, indexed by the status_reg bit each one tests.
  localparam logic [5:0][OPCODE_W-1:0] CJ_OPS = {OP_JLE, OP_JL, OP_JBE, OP_JB, OP_JNE, OP_JEQ};

  typedef enum logic {ST_RUN, ST_WAIT_FLAGS} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [OPCODE_W-1:0]   w_opcode;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [IMM_W-1:0]      w_imm_field;
  logic [PC_W-1:0]       w_target;
  logic [5:0]            w_cj_match;
  logic                  w_is_cj;
  logic                  w_cj_take;
  logic                  w_is_cmp;
  logic                  w_blocked;
  logic                  w_instr_ready;
  logic                  w_accept;
  logic                  w_unused_flags;

  logic [3:0]            w_alu_op;
  logic [REG_ADDR_W-1:0] w_src1;
  logic [REG_ADDR_W-1:0] w_src2;
  logic [REG_ADDR_W-1:0] w_dest;
  logic                  w_rr;
  logic                  w_rwe;
  logic                  w_imm;
  logic                  w_load_pc;
  logic                  w_mem_rd;
  logic                  w_mem_wr;
  logic                  w_mem_data_in;
  logic [DATA_W-1:0]     w_imm_val;
  logic [PC_W-1:0]       w_load_pc_val;
  logic                  w_illegal;

  logic                  r_dec_valid;
  logic [3:0]            r_alu_op;
  logic [REG_ADDR_W-1:0] r_src1;
  logic [REG_ADDR_W-1:0] r_src2;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_rwe;
  logic                  r_imm;
  logic                  r_load_pc;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic                  r_mem_data_in;
  logic [DATA_W-1:0]     r_imm_val;
  logic [PC_W-1:0]       r_load_pc_val;
  logic                  r_illegal;

  assign w_opcode    = instruction[DATA_W-1 -: OPCODE_W];
  assign w_rs        = instruction[DATA_W-OPCODE_W-1 -: REG_ADDR_W];
  assign w_rt        = instruction[DATA_W-OPCODE_W-REG_ADDR_W-1 -: REG_ADDR_W];
  assign w_rd        = instruction[DATA_W-OPCODE_W-2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign w_imm_field = instruction[IMM_W-1:0];
  assign w_target    = instruction[PC_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_cj
      assign w_cj_match[gi] = (w_opcode == CJ_OPS[gi]);
    end
  endgenerate

  assign w_is_cj        = |w_cj_match;
  assign w_cj_take      = |(w_cj_match & status_reg[5:0]);
  assign w_is_cmp       = (w_opcode == OP_CMP);
  assign w_unused_flags = ^status_reg;

  // A Jcc after a CMP must see the fresh flags; the update pulse itself releases it.
  assign w_blocked     = (r_state == ST_WAIT_FLAGS) && w_is_cj && !flags_update;
  assign w_instr_ready = !rst && !flush && (!r_dec_valid || dec_ready) && !w_blocked;
  assign w_accept      = instr_valid && w_instr_ready;

  always_comb begin
    w_alu_op      = 4'd0;
    w_src1        = '0;
    w_src2        = '0;
    w_dest        = '0;
    w_rr          = 1'b0;
    w_rwe         = 1'b0;
    w_imm         = 1'b0;
    w_load_pc     = 1'b0;
    w_mem_rd      = 1'b0;
    w_mem_wr      = 1'b0;
    w_mem_data_in = 1'b0;
    w_imm_val     = '0;
    w_load_pc_val = '0;
    w_illegal     = 1'b0;
    case (w_opcode)
      OP_NOP:  ;
      OP_ADD:  begin w_alu_op = 4'd1; w_rr = 1'b1; end
      OP_SUB:  begin w_alu_op = 4'd2; w_rr = 1'b1; end
      OP_MUL:  begin w_alu_op = 4'd3; w_rr = 1'b1; end
      OP_AND:  begin w_alu_op = 4'd4; w_rr = 1'b1; end
      OP_OR:   begin w_alu_op = 4'd5; w_rr = 1'b1; end
      OP_XOR:  begin w_alu_op = 4'd6; w_rr = 1'b1; end
      OP_XNOR: begin w_alu_op = 4'd7; w_rr = 1'b1; end
      OP_SHL:  begin w_alu_op = 4'd8; w_rr = 1'b1; end
      OP_SHR:  begin w_alu_op = 4'd9; w_rr = 1'b1; end
      OP_JMP: begin
        w_load_pc     = 1'b1;
        w_load_pc_val = w_target;
      end
      OP_LUI: begin
        w_dest    = w_rs;
        w_imm     = 1'b1;
        w_rwe     = 1'b1;
        w_imm_val = {w_imm_field, {(DATA_W-IMM_W){1'b0}}};
      end
      OP_LLI: begin
        w_alu_op  = 4'd5;
        w_src2    = w_rs;
        w_dest    = w_rs;
        w_imm     = 1'b1;
        w_rwe     = 1'b1;
        w_imm_val = {{(DATA_W-IMM_W){1'b0}}, w_imm_field};
      end
      OP_CMP: begin
        w_alu_op = 4'd2;
        w_src1   = w_rs;
        w_src2   = w_rt;
      end
      OP_LOD: begin
        w_src1        = w_rt;
        w_dest        = w_rs;
        w_rwe         = 1'b1;
        w_mem_rd      = 1'b1;
        w_mem_data_in = 1'b1;
      end
      OP_STR: begin
        w_src1   = w_rt;
        w_src2   = w_rs;
        w_mem_wr = 1'b1;
      end
      default: begin
        if (w_is_cj) begin
          w_load_pc     = w_cj_take;
          w_load_pc_val = w_target;
        end else begin
          w_illegal = 1'b1;
        end
      end
    endcase
    if (w_rr) begin
      w_src1 = w_rs;
      w_src2 = w_rt;
      w_dest = w_rd;
      w_rwe  = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:        if (w_accept && w_is_cmp) w_state_next = ST_WAIT_FLAGS;
        ST_WAIT_FLAGS: if (flags_update && !(w_accept && w_is_cmp)) w_state_next = ST_RUN;
        default:       w_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_valid   <= 1'b0;
      r_alu_op      <= 4'd0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_dest        <= '0;
      r_rwe         <= 1'b0;
      r_imm         <= 1'b0;
      r_load_pc     <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_data_in <= 1'b0;
      r_imm_val     <= '0;
      r_load_pc_val <= '0;
      r_illegal     <= 1'b0;
    end else if (flush) begin
      r_dec_valid <= 1'b0;
    end else if (w_accept) begin
      r_dec_valid   <= 1'b1;
      r_alu_op      <= w_alu_op;
      r_src1        <= w_src1;
      r_src2        <= w_src2;
      r_dest        <= w_dest;
      r_rwe         <= w_rwe;
      r_imm         <= w_imm;
      r_load_pc     <= w_load_pc;
      r_mem_rd      <= w_mem_rd;
      r_mem_wr      <= w_mem_wr;
      r_mem_data_in <= w_mem_data_in;
      r_imm_val     <= w_imm_val;
      r_load_pc_val <= w_load_pc_val;
      r_illegal     <= w_illegal;
    end else if (dec_ready) begin
      r_dec_valid <= 1'b0;
    end
  end

  assign instr_ready      = w_instr_ready;
  assign dec_valid        = r_dec_valid;
  assign alu_op           = r_alu_op;
  assign alu_src1         = r_src1;
  assign alu_src2         = r_src2;
  assign alu_dest         = r_dest;
  assign reg_write_enable = r_rwe;
  assign imm              = r_imm;
  assign load_pc          = r_load_pc;
  assign mem_rd           = r_mem_rd;
  assign mem_wr           = r_mem_wr;
  assign mem_data_in      = r_mem_data_in;
  assign imm_val          = r_imm_val;
  assign load_pc_val      = r_load_pc_val;
  assign illegal          = r_illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the microcpu datapath. It sits between the fetch unit and the ALU/register-file/memory stage, with a valid/ready handshake on both sides. The opcode map is unchanged from the existing combinational decoder. The stage adds four things on top of that map:
- one-cycle registered output with backpressure;
- an interlock that holds conditional jumps until the flags from a preceding CMP are valid;
- illegal-opcode detection;
- a synchronous flush.

## Interface
- DATA_W, 32: instruction/data width.
- OPCODE_W, 6: opcode field width, located at instruction[DATA_W-1 -: OPCODE_W].
- REG_ADDR_W, 5: register-address field width.
- IMM_W, 16: immediate field width, located at instruction[IMM_W-1:0]. Must satisfy 2*IMM_W <= DATA_W.
- FLAG_W, 8: status register width. Must be >= 6.
- PC_W, DATA_W-OPCODE_W: jump target width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard the registered output and any pending interlock.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  decoder accepts the instruction this cycle.
- instruction  in  DATA_W  instruction word.
- status_reg  in  FLAG_W  flags: [0] eq, [1] ne, [2] gt, [3] ge, [4] lt, [5] le.
- flags_update  in  1  one-cycle pulse meaning status_reg now reflects the last CMP.
- dec_valid  out  1  registered decode is valid.
- dec_ready  in  1  downstream consumes the decode.
- alu_op  out  4  NOP 0, ADD 1, SUB 2, MUL 3, AND 4, OR 5, XOR 6, XNOR 7, SHL 8, SHR 9.
- alu_src1, alu_src2, alu_dest  out  REG_ADDR_W each  register indices.
- reg_write_enable, imm, load_pc, mem_rd, mem_wr, mem_data_in  out  1 each  control signals.
- imm_val  out  DATA_W  immediate value.
- load_pc_val  out  PC_W  jump target.
- illegal  out  1  registered decode was an undefined opcode.

## Operation
Field positions (generalised):
- rs = bits [DATA_W-OPCODE_W-1 -: REG_ADDR_W].
- rt = the next REG_ADDR_W bits below rs.
- rd = the next REG_ADDR_W bits below rt.
- target = bits [PC_W-1:0].

Per-opcode decode:
- NOP 0x00: all controls 0.
- ALU ops (ADD 0x01, SUB 0x02, MUL 0x03, AND 0x04, OR 0x05, XOR 0x0E, XNOR 0x0F, SHL 0x10, SHR 0x11): src1=rs, src2=rt, dest=rd, reg_write_enable=1.
- JMP 0x06: load_pc=1, load_pc_val=target.
- LUI 0x07: dest=rs, imm=1, reg_write_enable=1, imm_val = imm field placed in bits [DATA_W-1 -: IMM_W], low bits zero.
- LLI 0x08: alu_op=OR, src1=0, src2=dest=rs, imm=1, reg_write_enable=1, imm_val = imm field zero-extended.
- CMP 0x0A: alu_op=SUB, src1=rs, src2=rt, reg_write_enable=0.
- Conditional jumps JEQ 0x0B, JNE 0x12, JB 0x13, JBE 0x14, JL 0x15, JLE 0x16: load_pc = status_reg bit 0, 1, 2, 3, 4, 5 respectively, sampled in the acceptance cycle. load_pc_val=target.
- LOD 0x0C: src1=rt, dest=rs, reg_write_enable=1, mem_rd=1, mem_data_in=1.
- STR 0x0D: src1=rt, src2=rs, mem_wr=1.
- Any other opcode: all controls 0 (NOP-equivalent) and illegal=1.
- Every unlisted output is 0 in all cases.

Interlock state machine:
- RUN: accepting a CMP moves to WAIT_FLAGS.
- WAIT_FLAGS: a conditional jump at the input is blocked (instr_ready=0) unless flags_update=1 in the same cycle.
  - On flags_update: go to RUN, unless a CMP is accepted in that same cycle, in which case stay in WAIT_FLAGS.
  - Non-conditional instructions are accepted normally in this state.
- flush or rst: go to RUN.

Handshake:
- instr_ready = !rst && !flush && (!dec_valid || dec_ready) && !blocked.
- Acceptance (instr_valid && instr_ready) loads the output register and sets dec_valid=1.
- dec_valid with dec_ready and no new acceptance sets dec_valid=0.
- While dec_valid=1 and dec_ready=0, all outputs hold stable.

## Timing
- Latency: the decode appears on the cycle after acceptance.
- Throughput: one instruction per cycle when dec_ready=1.
- Reset: dec_valid=0, instr_ready=0, state RUN. Every decode output (including illegal, imm_val, load_pc_val) is 0.
- flush: in the next cycle, dec_valid=0 and state is RUN. instr_ready=0 during the flush cycle. flush takes priority over acceptance and over dec_ready.
- Conditional-jump flag sampling: status_reg is sampled in the acceptance cycle, including the cycle where flags_update releases the block.
- Output controls are qualified by dec_valid only. The downstream stage must ignore them when dec_valid=0.

## Test plan
- After reset: ADD r1,r2→r3 (0x0422_1800) with dec_ready=1 → next cycle dec_valid=1, alu_op=1, src1=1, src2=2, dest=3, reg_write_enable=1.
- Backpressure: stream ADD, SUB, MUL with dec_ready held 0 for 3 cycles → instr_ready=0 and outputs hold the ADD decode. Release → SUB, then MUL, each on one cycle, none lost or duplicated.
- Interlock: CMP, then JEQ 0x100 → JEQ is blocked until a flags_update pulse with status_reg=0x01. Decode then shows load_pc=1, load_pc_val=0x100. Repeat with status_reg=0x02 → load_pc=0.
- LUI r4,0xABCD then LLI r4,0x1234 → imm_val=0xABCD_0000 with dest=4, then imm_val=0x0000_1234 with alu_op=5, src2=4.
- Opcode 0x3F → illegal=1 and all controls 0. The next valid instruction decodes with illegal=0.
- flush while in WAIT_FLAGS with dec_valid=1 → next cycle dec_valid=0, and a following JNE is accepted immediately.
